// File: rtl/uart_tx_fifo_if.sv
// CPU-side byte handshake for the buffered UART transmitter.
// The CPU offers data_in with data_valid; the transmitter's FIFO raises data_ready_o when it has room.
interface uart_tx_fifo_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready_o;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready_o
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeds a start/data/stop serialiser.
// Queued frames are sent back to back, with no idle cycle between a stop bit and the next start bit.
module uart_tx_fifo #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_MHZ  = 10_00_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    uart_tx_fifo_if.slave                      bus,
    output logic                               bits,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
    localparam int CLKS_PER_BIT = CLOCK_MHZ / BAUD_RATE;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_fifo: CLOCK_MHZ / BAUD_RATE must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          bits_q, bits_d;
    logic          push, pop, baud_last, ready;

    // Ready comes only from the registered count, so a same-cycle pop never frees a full FIFO.
    assign ready     = (count_q != CW'(FIFO_DEPTH));
    assign push      = bus.data_valid && ready;
    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

    assign bus.data_ready_o = ready;
    assign bits             = bits_q;
    assign fifo_count       = count_q;
    assign busy             = (state_q != S_IDLE) || (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        bits_d    = bits_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                bits_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = S_START;
                    bits_d  = 1'b0;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                    bits_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        bits_d  = 1'b1;
                    end else begin
                        // Next bit is shift_q[1], which becomes shift[0] after this shift.
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        bits_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = S_START;
                        bits_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        bits_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                bits_d  = 1'b1;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            bits_q    <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            bits_q    <= bits_d;
        end
    end
endmodule
